// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one shift per clock)
// with valid/ready on both sides. Define BCD_BLANK_EN to get a leading-zero blank mask.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      in_bin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_overflow,
    output logic [DIGITS-1:0]     out_blank,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SW    = BCD_W + BIN_W;
    localparam int CW    = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_n;
    logic [SW-1:0]     scratch, scratch_n, adjusted;
    logic [CW-1:0]     count, count_n;
    logic              sticky, sticky_n;
    logic              load;
    logic [BCD_W-1:0]  bcd_q;
    logic              ovf_q;

    // Add-3 correction on every BCD digit before the shift; digits never carry into each other.
    always_comb begin
        adjusted = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[BIN_W+4*d +: 4] >= 4'd5)
                adjusted[BIN_W+4*d +: 4] = scratch[BIN_W+4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_n   = state;
        scratch_n = scratch;
        count_n   = count;
        sticky_n  = sticky;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    scratch_n = {{BCD_W{1'b0}}, in_bin};
                    count_n   = '0;
                    sticky_n  = 1'b0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                // Any bit leaving the top digit means the value needs more digits than we have.
                scratch_n = {adjusted[SW-2:0], 1'b0};
                sticky_n  = sticky | adjusted[SW-1];
                count_n   = count + CW'(1);
                if (count_n == CW'(BIN_W)) begin
                    load    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            scratch <= '0;
            count   <= '0;
            sticky  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_n;
            scratch <= scratch_n;
            count   <= count_n;
            sticky  <= sticky_n;
            if (load) begin
                bcd_q <= scratch_n[SW-1:BIN_W];
                ovf_q <= sticky_n;
            end
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_calc;
    logic              upper_zero;

    // Bit k blanks digit k when it and everything above it is zero; the ones digit always shows.
    always_comb begin
        blank_calc = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero    = upper_zero & (scratch_n[BIN_W+4*k +: 4] == 4'd0);
            blank_calc[k] = upper_zero & ~sticky_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            blank_q <= '0;
        else if (load)
            blank_q <= blank_calc;
    end

    assign out_blank = blank_q;
`else
    assign out_blank = '0;
`endif

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign out_bcd      = bcd_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default 14-bit/4-digit instance plus
// two small configurations, all compared against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] in_bin = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_bcd;
    logic        out_overflow;
    logic [3:0]  out_blank;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [7:0]  binB = '0;
    logic [9:0]  binC = '0;
    logic        validS = 1'b0;
    logic        readyB, readyC, vB, vC, ovfB, ovfC;
    logic [11:0] bcdB;
    logic [7:0]  bcdC;
    logic [2:0]  blankB;
    logic [1:0]  blankC;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq dut (
        .clk(clk), .rst(rst), .in_bin(in_bin), .in_valid(in_valid), .in_ready(in_ready),
        .out_bcd(out_bcd), .out_overflow(out_overflow), .out_blank(out_blank),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dutB (
        .clk(clk), .rst(rst), .in_bin(binB), .in_valid(validS), .in_ready(readyB),
        .out_bcd(bcdB), .out_overflow(ovfB), .out_blank(blankB),
        .out_valid(vB), .out_ready(1'b1)
    );

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(2)) dutC (
        .clk(clk), .rst(rst), .in_bin(binC), .in_valid(validS), .in_ready(readyC),
        .out_bcd(bcdC), .out_overflow(ovfC), .out_blank(blankC),
        .out_valid(vC), .out_ready(1'b1)
    );

    // Decimal reference model built on plain integer arithmetic.
    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic longint ovfModel(input longint v, input int d);
        return (v >= pow10(d)) ? 1 : 0;
    endfunction

    function automatic longint bcdModel(input longint v, input int d);
        longint m = v % pow10(d);
        longint r = 0;
        for (int k = 0; k < d; k++) r = r | (((m / pow10(k)) % 10) << (4 * k));
        return r;
    endfunction

    function automatic longint blankModel(input longint v, input int d);
        longint r = 0;
`ifdef BCD_BLANK_EN
        if (v < pow10(d))
            for (int k = 1; k < d; k++)
                if (v < pow10(k)) r = r | (longint'(1) << k);
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One conversion on the default instance, holding off the consumer for holdCycles cycles.
    task automatic applyStimulus(input logic [13:0] v, input int holdCycles);
        int lat;
        @(negedge clk);
        in_bin   = v;
        in_valid = 1'b1;
        checkOutput("in_ready_idle", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bin   = 14'($urandom);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        checkOutput("latency", longint'(lat), 14);
        checkOutput("bcd", longint'(out_bcd), bcdModel(longint'(v), 4));
        checkOutput("overflow", longint'(out_overflow), ovfModel(longint'(v), 4));
        checkOutput("blank", longint'(out_blank), blankModel(longint'(v), 4));
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'b1;
            in_bin   = 14'($urandom);
            @(negedge clk);
            checkOutput("hold_valid", longint'(out_valid), 1);
            checkOutput("hold_bcd", longint'(out_bcd), bcdModel(longint'(v), 4));
            checkOutput("hold_in_ready", longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("valid_dropped", longint'(out_valid), 0);
        checkOutput("ready_after_hs", longint'(in_ready), 1);
        checkOutput("bcd_retained", longint'(out_bcd), bcdModel(longint'(v), 4));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int latB, latC;
        logic [11:0] capB;
        logic [7:0]  capC;
        logic        capOvfB, capOvfC;
        logic [2:0]  capBlB;
        logic [1:0]  capBlC;

        repeat (3) @(negedge clk);
        checkOutput("reset_valid", longint'(out_valid), 0);
        checkOutput("reset_bcd", longint'(out_bcd), 0);
        checkOutput("reset_ovf", longint'(out_overflow), 0);
        checkOutput("reset_blank", longint'(out_blank), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", longint'(in_ready), 1);

        applyStimulus(14'd1234, 0);
        applyStimulus(14'd0, 0);
        applyStimulus(14'd7, 1);
        applyStimulus(14'd9999, 10);
        applyStimulus(14'd10000, 0);
        applyStimulus(14'd16383, 2);

        // Abort a conversion partway through with reset.
        @(negedge clk);
        in_bin   = 14'd4321;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_valid", longint'(out_valid), 0);
        checkOutput("abort_in_ready", longint'(in_ready), 1);
        checkOutput("abort_bcd", longint'(out_bcd), 0);
        applyStimulus(14'd55, 0);

        for (int i = 0; i < 20; i++)
            applyStimulus(14'($urandom_range(0, 16383)), int'($urandom_range(0, 3)));

        // Small configurations: both accept together, results captured when each pulses valid.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            binB   = (i == 0) ? 8'd255 : 8'($urandom);
            binC   = (i == 0) ? 10'd100 : 10'($urandom_range(0, 1023));
            validS = 1'b1;
            @(posedge clk);
            #1;
            validS = 1'b0;
            latB = 0; latC = 0;
            capB = '0; capC = '0; capOvfB = 1'b0; capOvfC = 1'b0; capBlB = '0; capBlC = '0;
            for (int lat = 1; lat <= 20; lat++) begin
                @(posedge clk);
                @(negedge clk);
                if (vB && latB == 0) begin
                    latB = lat; capB = bcdB; capOvfB = ovfB; capBlB = blankB;
                end
                if (vC && latC == 0) begin
                    latC = lat; capC = bcdC; capOvfC = ovfC; capBlC = blankC;
                end
            end
            checkOutput("w8_latency", longint'(latB), 8);
            checkOutput("w8_bcd", longint'(capB), bcdModel(longint'(binB), 3));
            checkOutput("w8_ovf", longint'(capOvfB), ovfModel(longint'(binB), 3));
            checkOutput("w8_blank", longint'(capBlB), blankModel(longint'(binB), 3));
            checkOutput("w10_latency", longint'(latC), 10);
            checkOutput("w10_bcd", longint'(capC), bcdModel(longint'(binC), 2));
            checkOutput("w10_ovf", longint'(capOvfC), ovfModel(longint'(binC), 2));
            checkOutput("w10_blank", longint'(capBlC), blankModel(longint'(binC), 2));
            checkOutput("w8_idle", longint'(readyB), 1);
            checkOutput("w10_idle", longint'(readyC), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using shift-and-add-3, one shift per clock. It replaces the fixed 14-bit/4-digit free-running converter with a valid/ready handshake on both sides and an overflow flag. It sits between the measurement and averaging datapath and the seven-segment display driver, so any binary width can be matched to any display digit count.

Parameters:
BIN_W, 14, width of the unsigned binary input (>=2)
DIGITS, 4, number of BCD output digits (>=1); output field is 4*DIGITS bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_bin  in  BIN_W  unsigned binary operand
in_valid  in  1  operand available
in_ready  out  1  converter can accept an operand (high only in IDLE)
out_bcd  out  4*DIGITS  packed BCD result; digit k is bits [4k+3:4k], digit 0 is the ones digit
out_overflow  out  1  in_bin > 10^DIGITS-1; out_bcd then holds the low DIGITS decimal digits
out_blank  out  DIGITS  leading-zero blank mask (see Optional Feature)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset is synchronous and active-high on clk. Reset state: IDLE; out_bcd=0, out_overflow=0, out_blank=0, out_valid=0; internal scratch, counter and sticky flag cleared.
- Reset mid-conversion or in DONE aborts immediately. The in-flight result is discarded and is never presented.
- Internal registers:
  - scratch of 4*DIGITS+BIN_W bits: BCD field high, binary field low.
  - shift counter, $clog2(BIN_W+1) bits.
  - sticky overflow bit.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1 combinationally.
  - On in_valid && in_ready at an edge: scratch = {0, in_bin}, counter=0, sticky=0, state moves to SHIFT.
- SHIFT, one iteration per cycle:
  - First, every BCD digit >=5 gets +3 (4-bit add; no carry between digits).
  - Then scratch shifts left by 1. The bit shifted out of the top of the BCD field is ORed into sticky.
  - Counter increments. On the edge where the counter reaches BIN_W: register out_bcd = BCD field, out_overflow = sticky (including that edge's shifted-out bit), out_valid=1, state moves to DONE.
- Latency: out_valid rises exactly BIN_W clock edges after the accepting edge.
- DONE:
  - Outputs are held stable while out_valid && !out_ready.
  - On out_valid && out_ready at an edge: out_valid=0, state moves to IDLE. out_bcd, out_overflow and out_blank retain their last values.
- Throughput: one conversion per BIN_W+2 cycles when out_ready is tied high. in_ready is low in SHIFT and DONE; in_valid there is ignored and does not need to be held.
- in_bin is sampled only on the accepting edge. Later changes to in_bin do not affect the conversion.
- Boundaries:
  - in_bin=0 gives all-zero BCD with no overflow.
  - in_bin = 10^DIGITS-1 gives all-9 digits with overflow=0.
  - in_bin = 10^DIGITS gives all-0 digits with overflow=1.
  - If BIN_W is small enough that overflow is impossible, out_overflow stays 0.
- No combinational path exists from in_valid or out_ready to any output other than in_ready, which depends only on state.

Optional Feature:
Macro BCD_BLANK_EN.
- Defined: out_blank is registered together with out_bcd. Bit k=1 iff digit k and all higher digits are 0, for k>=1. Bit 0 is always 0, so the ones digit is always shown. If out_overflow=1, out_blank=0.
- Undefined: out_blank is driven constant 0 and no blanking logic is synthesised. The port list is identical either way.

Test Plan:
- Defaults, in_bin=1234, out_ready=1 -> out_valid exactly 14 edges after accept; out_bcd=16'h1234; overflow=0; blank=4'b0000 (BCD_BLANK_EN defined).
- in_bin=0, then in_bin=7, with BCD_BLANK_EN defined -> 16'h0000 with blank=4'b1110; then 16'h0007 with blank=4'b1110. Macro undefined -> blank=0 in both cases.
- in_bin=9999, then 10000, then 16383 -> results in order: {16'h9999, ovf 0}, {16'h0000, ovf 1}, {16'h6383, ovf 1}; blank=0 on both overflow results.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_bcd and out_valid stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> one handshake, then in_ready=1 on the next cycle.
- Reset asserted at shift 6 of in_bin=4321 -> out_valid=0 and in_ready=1 after the reset edge. A following conversion of 55 yields 16'h0055 with no trace of 4321.
- BIN_W=8, DIGITS=3: in_bin=255 -> 12'h255, latency 8, overflow=0. BIN_W=10, DIGITS=2: in_bin=100 -> 8'h00 with overflow=1.
